long_latency_scoreboard: RTL and testbench
==========================================

Name: long_latency_scoreboard

Overview:
- Producer-side hazard tracker for destination registers written by long-latency operations (loads, mul/div, vector results) whose data cannot reach EX through MEM/WB forwarding in time.
- Marks rd pending at issue and clears it on the completion writeback.
- Holds the decode/issue stage while any source or destination of the incoming instruction is still pending.
- Sits beside the forwarding unit. Forwarding covers single-cycle producers; this block covers everything else.

Parameters:
- NUM_REGS, 32, architectural register count; index 0 is hardwired zero.
- MAX_OUTSTANDING, 4, maximum in-flight long-latency operations.
- STALL_CNT_WIDTH, 32, width of the saturating stall performance counter.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  decode presents an instruction.
- issue_rs1_addr  input  5  source 1 (x0 = unused).
- issue_rs2_addr  input  5  source 2 (x0 = unused).
- issue_rd_addr  input  5  destination.
- issue_reg_write  input  1  instruction writes rd.
- issue_long  input  1  instruction is long-latency.
- issue_ready  output  1  combinational; instruction may issue this cycle.
- cmpl_valid  input  1  long-latency result written back this cycle.
- cmpl_rd_addr  input  5  completing destination.
- flush  input  1  kill all in-flight long-latency ops.
- pending  output  NUM_REGS  registered pending bitmap; bit 0 always 0.
- outstanding  output  $clog2(MAX_OUTSTANDING+1)  in-flight count.
- stall_count  output  STALL_CNT_WIDTH  cycles with issue_valid=1 and issue_ready=0, saturating.
- err_spurious  output  1  sticky; completion arrived with no matching in-flight op.

Behaviour:
- Reset (async, rst_n=0): pending=0, outstanding=0, stall_count=0, err_spurious=0. issue_ready evaluates combinationally from the cleared state (=1 when nothing is pending).
- Completion bypass:
  - cmpl_hit = cmpl_valid & (cmpl_rd_addr==0 ? outstanding>0 : pending[cmpl_rd_addr]).
  - Effective pending eff = pending with bit cmpl_rd_addr cleared when cmpl_hit.
- Hazards, all evaluated against eff; x0 is never a hazard:
  - raw = eff[rs1] | eff[rs2].
  - waw = issue_reg_write & eff[rd].
  - full = issue_long & (outstanding - cmpl_hit == MAX_OUTSTANDING).
- issue_ready = !raw & !waw & !full & !flush.
- fire = issue_valid & issue_ready.
- Next-state update:
  - pending[rd] set when fire & issue_long & issue_reg_write & rd!=0.
  - pending[cmpl_rd_addr] cleared when cmpl_hit.
  - Same-rd clear and set in one cycle: set wins.
  - outstanding_next = outstanding + (fire & issue_long) - cmpl_hit. A long op with rd=x0 or reg_write=0 still counts and completes with cmpl_rd_addr=0.
- Spurious completion: cmpl_valid & !cmpl_hit sets err_spurious, which holds until reset. The completion is otherwise ignored: no decrement, no bit change.
- Flush:
  - Next cycle pending=0 and outstanding=0.
  - Issue is blocked during the flush cycle.
  - Completions in the flush cycle are discarded without error.
  - Completions in later cycles for killed ops are upstream's responsibility to suppress; if they arrive they flag err_spurious.
- stall_count increments by 1 per cycle with issue_valid & !issue_ready, including flush cycles, and saturates at all-ones.
- Single completion port: at most one clear per cycle.

Test Plan:
- Reset then issue long lw x5 (rd=5) -> next cycle pending=0x20, outstanding=1; a following add x6,x5,x1 -> issue_ready=0. cmpl rd=5 -> issue_ready=1 in that same cycle (bypass); next cycle pending=0.
- Issue rd=7 long while cmpl_valid rd=7 in the same cycle, with x7 pending -> issue fires and the pending[7] bit remains set; outstanding unchanged.
- Issue 4 long ops to x1..x4 (MAX_OUTSTANDING=4), then a 5th long op to x8 -> issue_ready=0 and stall_count increments. A simultaneous cmpl rd=1 -> 5th fires; outstanding stays 4.
- Uses of x0: rs1=0, rd=0 with eff all zero -> never stalls. Long op with rd=0 -> outstanding +1, pending unchanged; cmpl rd=0 -> outstanding back to 0.
- cmpl_valid rd=9 with x9 not pending -> err_spurious=1 (sticky), outstanding unchanged; only reset clears it.
- With 3 pending, assert flush together with issue_valid -> issue_ready=0 that cycle; next cycle pending=0, outstanding=0. Assert rst_n=0 mid-operation -> all outputs clear immediately, asynchronously.

Source files
------------

// File: rtl/long_latency_scoreboard.sv
// Pending-register scoreboard for long-latency producers; holds issue on RAW/WAW/full hazards.
// issue_ready is combinational with same-cycle completion bypass; state updates next cycle.
module long_latency_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STALL_CNT_WIDTH = 32,
  localparam int OW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [4:0]                 issue_rs1_addr,
  input  logic [4:0]                 issue_rs2_addr,
  input  logic [4:0]                 issue_rd_addr,
  input  logic                       issue_reg_write,
  input  logic                       issue_long,
  output logic                       issue_ready,
  input  logic                       cmpl_valid,
  input  logic [4:0]                 cmpl_rd_addr,
  input  logic                       flush,
  output logic [NUM_REGS-1:0]        pending,
  output logic [OW-1:0]              outstanding,
  output logic [STALL_CNT_WIDTH-1:0] stall_count,
  output logic                       err_spurious
);

  logic [NUM_REGS-1:0]        pend_q;
  logic [NUM_REGS-1:0]        clr_mask;
  logic [NUM_REGS-1:0]        set_mask;
  logic [NUM_REGS-1:0]        eff;
  logic [OW-1:0]              outs_q;
  logic [OW:0]                outs_after_cmpl;
  logic [STALL_CNT_WIDTH-1:0] stall_q;
  logic                       err_q;
  logic                       cmpl_hit;
  logic                       raw;
  logic                       waw;
  logic                       full;
  logic                       fire;
  logic                       fire_long;

  // A completion to x0 retires a long op that never marked a register.
  assign cmpl_hit = cmpl_valid &&
                    ((cmpl_rd_addr == 5'd0) ? (outs_q != '0) : pend_q[cmpl_rd_addr]);

  always_comb begin
    clr_mask = '0;
    if (cmpl_hit && cmpl_rd_addr != 5'd0) clr_mask[cmpl_rd_addr] = 1'b1;
  end

  assign eff = pend_q & ~clr_mask;

  assign raw             = eff[issue_rs1_addr] | eff[issue_rs2_addr];
  assign waw             = issue_reg_write & eff[issue_rd_addr];
  assign outs_after_cmpl = {1'b0, outs_q} - {{OW{1'b0}}, cmpl_hit};
  assign full            = issue_long && (outs_after_cmpl == (OW+1)'(MAX_OUTSTANDING));

  assign issue_ready = !raw && !waw && !full && !flush;
  assign fire        = issue_valid && issue_ready;
  assign fire_long   = fire && issue_long;

  always_comb begin
    set_mask = '0;
    if (fire_long && issue_reg_write && issue_rd_addr != 5'd0) set_mask[issue_rd_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      outs_q <= '0;
    end else if (flush) begin
      pend_q <= '0;
      outs_q <= '0;
    end else begin
      // OR-ing the set after the clear lets a same-rd reissue keep its bit.
      pend_q <= (pend_q & ~clr_mask) | set_mask;
      outs_q <= outs_q + OW'(fire_long) - OW'(cmpl_hit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (issue_valid && !issue_ready && stall_q != '1) stall_q <= stall_q + STALL_CNT_WIDTH'(1);
      // Completions landing in the flush cycle are dropped silently.
      if (cmpl_valid && !cmpl_hit && !flush) err_q <= 1'b1;
    end
  end

  assign pending      = pend_q;
  assign outstanding  = outs_q;
  assign stall_count  = stall_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Bench for long_latency_scoreboard: expected registered state is queued with each stimulus cycle
// and compared after the clock edge; combinational issue_ready is checked before the edge.
module tb_long_latency_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rs1_addr;
  logic [4:0]  issue_rs2_addr;
  logic [4:0]  issue_rd_addr;
  logic        issue_reg_write;
  logic        issue_long;
  logic        issue_ready;
  logic        cmpl_valid;
  logic [4:0]  cmpl_rd_addr;
  logic        flush;
  logic [31:0] pending;
  logic [2:0]  outstanding;
  logic [31:0] stall_count;
  logic        err_spurious;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       tag;
    logic [31:0] pend;
    int          outs;
  } exp_t;

  exp_t sb[$];

  long_latency_scoreboard dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue_valid     (issue_valid),
    .issue_rs1_addr  (issue_rs1_addr),
    .issue_rs2_addr  (issue_rs2_addr),
    .issue_rd_addr   (issue_rd_addr),
    .issue_reg_write (issue_reg_write),
    .issue_long      (issue_long),
    .issue_ready     (issue_ready),
    .cmpl_valid      (cmpl_valid),
    .cmpl_rd_addr    (cmpl_rd_addr),
    .flush           (flush),
    .pending         (pending),
    .outstanding     (outstanding),
    .stall_count     (stall_count),
    .err_spurious    (err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] p, input int o);
    exp_t e;
    e.tag  = tag;
    e.pend = p;
    e.outs = o;
    sb.push_back(e);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check({e.tag, "_pend"}, 64'(pending), 64'(e.pend));
      check({e.tag, "_outs"}, 64'(outstanding), 64'(e.outs));
    end
  endtask

  task automatic idle();
    issue_valid     = 1'b0;
    issue_rs1_addr  = 5'd0;
    issue_rs2_addr  = 5'd0;
    issue_rd_addr   = 5'd0;
    issue_reg_write = 1'b0;
    issue_long      = 1'b0;
    cmpl_valid      = 1'b0;
    cmpl_rd_addr    = 5'd0;
    flush           = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic lng);
    issue_valid     = 1'b1;
    issue_rs1_addr  = rs1;
    issue_rs2_addr  = rs2;
    issue_rd_addr   = rd;
    issue_reg_write = rw;
    issue_long      = lng;
  endtask

  task automatic cmpl(input logic [4:0] rd);
    cmpl_valid   = 1'b1;
    cmpl_rd_addr = rd;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("rst_pend", 64'(pending), 64'h0);
    check("rst_outs", 64'(outstanding), 64'h0);
    check("rst_stall", 64'(stall_count), 64'h0);
    check("rst_err", 64'(err_spurious), 64'h0);
    check("rst_ready", 64'(issue_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // lw x5, then dependent add stalls until the same-cycle completion bypass
    idle(); issue(5'd1, 5'd0, 5'd5, 1'b1, 1'b1); #1;
    check("lw_ready", 64'(issue_ready), 64'h1);
    push("lw", 32'h20, 1); cyc();
    idle(); issue(5'd5, 5'd1, 5'd6, 1'b1, 1'b0); #1;
    check("add_raw_ready", 64'(issue_ready), 64'h0);
    cmpl(5'd5); #1;
    check("add_bypass_ready", 64'(issue_ready), 64'h1);
    push("add_cmpl", 32'h0, 0); cyc();
    check("stall_zero", 64'(stall_count), 64'h0);

    // reissue to x7 while x7 completes: set wins over clear
    idle(); issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    push("x7_a", 32'h80, 1); cyc();
    idle(); issue(5'd0, 5'd0, 5'd7, 1'b1, 1'b1); cmpl(5'd7); #1;
    check("x7_waw_bypass", 64'(issue_ready), 64'h1);
    push("x7_same", 32'h80, 1); cyc();
    idle(); cmpl(5'd7);
    push("x7_done", 32'h0, 0); cyc();

    // fill to MAX_OUTSTANDING, then 5th long op stalls until a completion frees a slot
    for (int i = 1; i <= 4; i++) begin
      idle(); issue(5'd0, 5'd0, 5'(i), 1'b1, 1'b1);
      push($sformatf("fill%0d", i), 32'((1 << (i + 1)) - 2), i); cyc();
    end
    idle(); issue(5'd0, 5'd0, 5'd8, 1'b1, 1'b1); #1;
    check("full_ready", 64'(issue_ready), 64'h0);
    push("full_hold", 32'h1E, 4); cyc();
    check("full_stall", 64'(stall_count), 64'h1);
    cmpl(5'd1); #1;
    check("full_bypass_ready", 64'(issue_ready), 64'h1);
    push("full_swap", 32'h11C, 4); cyc();
    check("full_stall_hold", 64'(stall_count), 64'h1);
    idle(); cmpl(5'd2); push("drain2", 32'h118, 3); cyc();
    idle(); cmpl(5'd3); push("drain3", 32'h110, 2); cyc();
    idle(); cmpl(5'd4); push("drain4", 32'h100, 1); cyc();
    idle(); cmpl(5'd8); push("drain8", 32'h0, 0); cyc();

    // x0 is never a hazard; long op to x0 counts and retires via cmpl rd=0
    idle(); issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); #1;
    check("x0_ready", 64'(issue_ready), 64'h1);
    push("x0_short", 32'h0, 0); cyc();
    idle(); issue(5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
    push("x0_long", 32'h0, 1); cyc();
    idle(); cmpl(5'd0);
    push("x0_cmpl", 32'h0, 0); cyc();
    check("x0_err", 64'(err_spurious), 64'h0);

    // flush with 3 pending; a stray completion in the flush cycle is not an error
    for (int i = 0; i < 3; i++) begin
      idle(); issue(5'd0, 5'd0, 5'(10 + i), 1'b1, 1'b1);
      push($sformatf("pre_flush%0d", i), 32'((1 << (11 + i)) - 32'h400), i + 1); cyc();
    end
    idle(); issue(5'd0, 5'd0, 5'd13, 1'b1, 1'b1); flush = 1'b1; cmpl(5'd20); #1;
    check("flush_ready", 64'(issue_ready), 64'h0);
    push("flush", 32'h0, 0); cyc();
    check("flush_stall", 64'(stall_count), 64'h2);
    check("flush_no_err", 64'(err_spurious), 64'h0);

    // spurious completion is sticky and changes nothing else
    idle(); cmpl(5'd9);
    push("spur", 32'h0, 0); cyc();
    check("spur_err", 64'(err_spurious), 64'h1);
    idle(); push("spur_hold", 32'h0, 0); cyc();
    check("spur_sticky", 64'(err_spurious), 64'h1);

    // asynchronous reset mid-operation
    idle(); issue(5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
    push("pre_arst", 32'h20, 1); cyc();
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_pend", 64'(pending), 64'h0);
    check("arst_outs", 64'(outstanding), 64'h0);
    check("arst_stall", 64'(stall_count), 64'h0);
    check("arst_err", 64'(err_spurious), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("sb_empty", 64'(sb.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
